display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexing scheduler for the 4-digit seven-segment display of the reaction timer. It snapshots four BCD digits once per frame and shares one segment decoder among the four digits. Each digit is enabled in turn for a programmable dwell, followed by an all-off guard interval against ghosting. It produces the one-hot digit select (bit 0 = rightmost digit, active high), the BCD nibble to decode, the decimal-point bit, a segment blank, and a per-frame strobe.

## Interface
- TICK_DIV, 50000: cycles each digit is driven (≥1)
- BLANK_CYCLES, 16: all-off guard cycles after each digit (≥0; 0 = no guard)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run scanning; sampled only at frame boundaries / IDLE
- digits  in  16  four BCD nibbles; [3:0] = digit 0 (rightmost) … [15:12] = digit 3
- dp_mask  in  4  decimal-point request per digit, bit i = digit i
- lz_blank  in  1  enable leading-zero suppression
- digit_sel  out  4  one-hot digit enable, 0000 when no digit driven
- bcd_out  out  4  nibble for the shared decoder
- dp_out  out  1  decimal point for current digit
- seg_blank  out  1  1 = decoder output must be forced off
- frame_done  out  1  one-cycle strobe at end of each completed frame

## Operation
- States: IDLE, LOAD, SHOW, GAP. Registered 2-bit idx, 2-bit `state`, dwell counter of width $clog2(max(TICK_DIV, BLANK_CYCLES, 2)), 16-bit digit shadow, 4-bit dp shadow.
- All outputs are registered / decoded from registered state only; no combinational input-to-output path.
- IDLE: digit_sel=0000, seg_blank=1, dp_out=0, bcd_out=0. If enable=1 → LOAD.
- LOAD (1 cycle): shadow ← digits, dp shadow ← dp_mask, idx ← 0, counter ← 0; outputs as IDLE → SHOW.
- SHOW: digit_sel = 1<<idx, bcd_out = shadow[idx], dp_out = dp shadow[idx]. Counter runs 0..TICK_DIV-1; on TICK_DIV-1 → GAP (or, if BLANK_CYCLES=0, directly to the end-of-slot step).
- GAP: digit_sel=0000, seg_blank=1, dp_out=0; lasts BLANK_CYCLES cycles.
- End of slot: if idx<3 → idx+1, SHOW. If idx=3 → frame complete: enable=1 → LOAD, else IDLE.
- seg_blank in SHOW = 1 if shadow[idx] > 9 (invalid BCD; bcd_out still carries raw nibble), or if lz_blank=1, idx≠0, dp shadow[idx]=0, and shadow digits idx..3 all zero. Digit 0 is never leading-zero blanked.
- Inputs digits/dp_mask changing mid-frame have no effect until the next LOAD (no tearing).
- enable falling mid-frame: current frame completes, then IDLE. enable toggling during a frame is ignored.
- reset at any cycle: next cycle state=IDLE, idx=0, counter=0, shadows=0, outputs at reset values.

## Timing
- Reset values: digit_sel=0000, bcd_out=0000, dp_out=0, seg_blank=1, frame_done=0.
- enable sampled 1 at edge k in IDLE → LOAD after k; SHOW idx0 (digit_sel=0001) after k+1.
- Each digit slot = TICK_DIV + BLANK_CYCLES cycles; frame with enable held = 1 + 4·(TICK_DIV+BLANK_CYCLES) cycles.
- frame_done = 1 exactly during the final cycle of digit 3's slot (last GAP cycle, or last SHOW cycle if BLANK_CYCLES=0); never during IDLE/LOAD.
- digit_sel is never multi-hot; transitions between two different non-zero values occur only when BLANK_CYCLES=0.

## Test plan
- TICK_DIV=4, BLANK_CYCLES=2, digits=16'h1234, enable held: digit_sel sequence 0001×4, 0000×2, 0010×4, 0000×2, 0100×4, 0000×2, 1000×4, 0000×2, with bcd_out 4,3,2,1; frame_done once per 25 cycles.
- lz_blank=1, digits=16'h0070, dp_mask=0: digit 3 and 2 seg_blank=1, digit 1 shows 7 seg_blank=0, digit 0 shows 0 seg_blank=0; repeat with dp_mask=4'b1000 → digit 3 not blanked, digit 2 still blanked.
- digits nibble 4'hB on digit 2: bcd_out=B, seg_blank=1 during its SHOW; others normal.
- Change digits from 16'h1234 to 16'h5678 while digit 1 is shown: remainder of frame shows 2,1; next frame shows 8,7,6,5.
- Drop enable during digit 1's SHOW: frame completes through digit 3, frame_done pulses, then IDLE with digit_sel=0000, seg_blank=1.
- Assert reset during digit 2's SHOW: next cycle all outputs at reset values; re-enable yields LOAD then digit_sel=0001 two cycles after enable sampled. BLANK_CYCLES=0 variant: slot=TICK_DIV, no 0000 gaps, frame=17 cycles at TICK_DIV=4.

Source files
------------

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - four-digit seven-segment scan scheduler with guard gaps
module display_scan_controller #(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        lz_blank,
    output logic [3:0]  digit_sel,
    output logic [3:0]  bcd_out,
    output logic        dp_out,
    output logic        seg_blank,
    output logic        frame_done
);
    localparam int MAX_TB  = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int MAX_ALL = (MAX_TB > 2) ? MAX_TB : 2;
    localparam int CW      = $clog2(MAX_ALL);

    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit            HAS_GAP    = (BLANK_CYCLES > 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state, state_n;
    logic [1:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   shadow, shadow_n;
    logic [3:0]    dp_shadow, dp_shadow_n;
    logic          slot_end;

    logic [3:0]    nib_n;
    logic          dp_bit_n;
    logic          upper_zero_n;
    logic          lz_hit_n;
    logic          last_cycle_n;

    // Next-state: dwell/guard counting, slot advance and frame wrap
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = cnt;
        shadow_n    = shadow;
        dp_shadow_n = dp_shadow;
        slot_end    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) state_n = S_LOAD;
            end
            S_LOAD: begin
                shadow_n    = digits;
                dp_shadow_n = dp_mask;
                idx_n       = 2'd0;
                cnt_n       = '0;
                state_n     = S_SHOW;
            end
            S_SHOW: begin
                if (cnt == TICK_LAST) begin
                    cnt_n = '0;
                    if (HAS_GAP) state_n = S_GAP;
                    else         slot_end = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == BLANK_LAST) begin
                    cnt_n    = '0;
                    slot_end = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase
        if (slot_end) begin
            if (idx != 2'd3) begin
                idx_n   = idx + 2'd1;
                state_n = S_SHOW;
            end else begin
                idx_n   = 2'd0;
                state_n = enable ? S_LOAD : S_IDLE;
            end
        end
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        nib_n    = shadow_n[{idx_n, 2'b00} +: 4];
        dp_bit_n = dp_shadow_n[idx_n];
        case (idx_n)
            2'd1:    upper_zero_n = (shadow_n[15:4] == 12'd0);
            2'd2:    upper_zero_n = (shadow_n[15:8] == 8'd0);
            2'd3:    upper_zero_n = (shadow_n[15:12] == 4'd0);
            default: upper_zero_n = 1'b0;
        endcase
        lz_hit_n     = lz_blank & upper_zero_n & ~dp_bit_n;
        last_cycle_n = (idx_n == 2'd3) &&
                       (HAS_GAP ? ((state_n == S_GAP) && (cnt_n == BLANK_LAST))
                                : ((state_n == S_SHOW) && (cnt_n == TICK_LAST)));
    end

    // State, shadow and registered output update
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            shadow     <= '0;
            dp_shadow  <= '0;
            digit_sel  <= 4'b0000;
            bcd_out    <= 4'b0000;
            dp_out     <= 1'b0;
            seg_blank  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            shadow     <= shadow_n;
            dp_shadow  <= dp_shadow_n;
            frame_done <= last_cycle_n;
            if (state_n == S_SHOW) begin
                digit_sel <= 4'b0001 << idx_n;
                bcd_out   <= nib_n;
                dp_out    <= dp_bit_n;
                seg_blank <= (nib_n > 4'd9) | lz_hit_n;
            end else begin
                digit_sel <= 4'b0000;
                bcd_out   <= 4'b0000;
                dp_out    <= 1'b0;
                seg_blank <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - randomized scoreboard bench for display_scan_controller
module tb_display_scan_controller;
    localparam int T0 = 4;
    localparam int B0 = 2;
    localparam int T1 = 4;
    localparam int B1 = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;

    logic [3:0] sel [2];
    logic [3:0] bcd [2];
    logic       dp [2];
    logic       blank [2];
    logic       fd [2];

    int checks = 0;
    int errors = 0;

    display_scan_controller #(.TICK_DIV(T0), .BLANK_CYCLES(B0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp_mask(dp_mask),
        .lz_blank(lz_blank), .digit_sel(sel[0]), .bcd_out(bcd[0]), .dp_out(dp[0]),
        .seg_blank(blank[0]), .frame_done(fd[0])
    );

    display_scan_controller #(.TICK_DIV(T1), .BLANK_CYCLES(B1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp_mask(dp_mask),
        .lz_blank(lz_blank), .digit_sel(sel[1]), .bcd_out(bcd[1]), .dp_out(dp[1]),
        .seg_blank(blank[1]), .frame_done(fd[1])
    );

    initial forever #5 clk = ~clk;

    // Reference: position within the frame (0 = load cycle, then 4 equal slots)
    int          m_run [2];
    int          m_p [2];
    logic [15:0] m_sh [2];
    logic [3:0]  m_dpm [2];
    logic        m_lz;

    function automatic int tk(int i);
        return (i == 0) ? T0 : T1;
    endfunction

    function automatic int bl(int i);
        return (i == 0) ? B0 : B1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_run[i] <= 0;
                m_p[i]   <= 0;
                m_sh[i]  <= 16'h0;
                m_dpm[i] <= 4'h0;
            end else if (m_run[i] == 0) begin
                if (enable) begin
                    m_run[i] <= 1;
                    m_p[i]   <= 0;
                end
            end else if (m_p[i] == 4 * (tk(i) + bl(i))) begin
                if (enable) m_p[i] <= 0;
                else        m_run[i] <= 0;
            end else begin
                if (m_p[i] == 0) begin
                    m_sh[i]  <= digits;
                    m_dpm[i] <= dp_mask;
                end
                m_p[i] <= m_p[i] + 1;
            end
        end
        m_lz <= lz_blank;
    end

    function automatic logic [10:0] exp_out(int i);
        int s, q, slot, off;
        logic [3:0] nib;
        logic dpb, blk, fdv;
        s = tk(i) + bl(i);
        if (m_run[i] == 0 || m_p[i] == 0) return 11'b0000_0000_010;
        q    = m_p[i] - 1;
        slot = q / s;
        off  = q % s;
        fdv  = (slot == 3) && (off == s - 1);
        if (off >= tk(i)) return {8'h00, 1'b0, 1'b1, fdv};
        nib = m_sh[i][4 * slot +: 4];
        dpb = m_dpm[i][slot];
        blk = (nib > 4'd9) || (m_lz && slot != 0 && !dpb && ((m_sh[i] >> (4 * slot)) == 16'h0));
        return {4'(1 << slot), nib, dpb, blk, fdv};
    endfunction

    function automatic logic [10:0] exp_mask(int i);
        if (m_run[i] != 0 && m_p[i] != 0 && ((m_p[i] - 1) % (tk(i) + bl(i))) >= tk(i))
            return 11'b1111_0000_111;
        return 11'h7FF;
    endfunction

    function automatic logic [10:0] obs(int i);
        return {sel[i], bcd[i], dp[i], blank[i], fd[i]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 11'b0000_0000_010) begin
                errors++;
                $display("FAIL reset_values dut%0d got=%h want=%h", i, obs(i), 11'b0000_0000_010);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_scan();
        int fdc [2];
        int c;
        logic [3:0] want_sel, want_bcd;
        digits = 16'h1234; dp_mask = 4'h0; lz_blank = 1'b0; enable = 1'b1;
        fdc[0] = 0; fdc[1] = 0;
        repeat (60) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ((obs(i) & exp_mask(i)) !== (exp_out(i) & exp_mask(i))) begin
                    errors++;
                    $display("FAIL basic_model dut%0d @%0t got=%h want=%h", i, $time, obs(i), exp_out(i));
                end
            end
        end
        repeat (425) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (fd[i] === 1'b1) fdc[i]++;
        end
        checks++;
        if (fdc[0] != 17) begin errors++; $display("FAIL basic_frame_rate_gap got=%0d want=17", fdc[0]); end
        checks++;
        if (fdc[1] != 25) begin errors++; $display("FAIL basic_frame_rate_nogap got=%0d want=25", fdc[1]); end
        c = 0;
        while (fd[0] !== 1'b1 && c < 40) begin @(negedge clk); c++; end
        checks++;
        if (c >= 40) begin errors++; $display("FAIL basic_fd_timeout got=none want=pulse"); end
        @(negedge clk);
        checks++;
        if (sel[0] !== 4'b0000) begin errors++; $display("FAIL basic_load_sel got=%b want=0000", sel[0]); end
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            want_sel = ((k % 6) < 4) ? 4'(1 << (k / 6)) : 4'b0000;
            want_bcd = 4'(4 - k / 6);
            checks++;
            if (sel[0] !== want_sel || (want_sel != 0 && bcd[0] !== want_bcd)) begin
                errors++;
                $display("FAIL basic_sequence k=%0d got=%b/%h want=%b/%h", k, sel[0], bcd[0], want_sel, want_bcd);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [3:0] want_blank;
        int d;
        digits = 16'h0070; dp_mask = 4'b0000; lz_blank = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) dp_mask = 4'b1000;
            want_blank = (phase == 0) ? 4'b1100 : 4'b0100;
            repeat (60) begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if ((obs(i) & exp_mask(i)) !== (exp_out(i) & exp_mask(i))) begin
                        errors++;
                        $display("FAIL lz_model dut%0d @%0t got=%h want=%h", i, $time, obs(i), exp_out(i));
                    end
                end
            end
            repeat (25) begin
                @(negedge clk);
                if (sel[0] != 4'b0000) begin
                    d = (sel[0] == 4'b0001) ? 0 : (sel[0] == 4'b0010) ? 1 : (sel[0] == 4'b0100) ? 2 : 3;
                    checks++;
                    if (blank[0] !== want_blank[d] || bcd[0] !== ((d == 1) ? 4'h7 : 4'h0)) begin
                        errors++;
                        $display("FAIL lz_digit%0d phase%0d got=blank%b/%h want=blank%b", d, phase, blank[0], bcd[0], want_blank[d]);
                    end
                end
            end
        end
        lz_blank = 1'b0; dp_mask = 4'h0;
    endtask

    task automatic test_invalid_bcd();
        digits = 16'h1B34;
        repeat (60) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ((obs(i) & exp_mask(i)) !== (exp_out(i) & exp_mask(i))) begin
                    errors++;
                    $display("FAIL invalid_model dut%0d @%0t got=%h want=%h", i, $time, obs(i), exp_out(i));
                end
            end
            if (sel[0] == 4'b0100) begin
                checks++;
                if (bcd[0] !== 4'hB || blank[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL invalid_digit2 got=%h/%b want=b/1", bcd[0], blank[0]);
                end
            end
        end
    endtask

    task automatic test_no_tearing();
        logic [3:0] seen [$];
        logic [3:0] want [6];
        logic [3:0] prev;
        int c;
        want = '{4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
        digits = 16'h1234;
        repeat (60) @(negedge clk);
        c = 0;
        while (sel[0] !== 4'b0010 && c < 60) begin @(negedge clk); c++; end
        checks++;
        if (c >= 60) begin errors++; $display("FAIL tear_wait got=none want=digit1"); end
        digits = 16'h5678;
        prev = sel[0];
        c = 0;
        while (seen.size() < 6 && c < 120) begin
            @(negedge clk);
            c++;
            if (sel[0] != 4'b0000 && prev == 4'b0000) seen.push_back(bcd[0]);
            prev = sel[0];
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ((obs(i) & exp_mask(i)) !== (exp_out(i) & exp_mask(i))) begin
                    errors++;
                    $display("FAIL tear_model dut%0d @%0t got=%h want=%h", i, $time, obs(i), exp_out(i));
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (k >= seen.size() || seen[k] !== want[k]) begin
                errors++;
                $display("FAIL tear_seq k=%0d got=%h want=%h", k, (k < seen.size()) ? seen[k] : 4'hx, want[k]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int c, fdc;
        c = 0;
        while (sel[0] !== 4'b0010 && c < 60) begin @(negedge clk); c++; end
        checks++;
        if (c >= 60) begin errors++; $display("FAIL drop_wait got=none want=digit1"); end
        enable = 1'b0;
        fdc = 0;
        repeat (80) begin
            @(negedge clk);
            if (fd[0] === 1'b1) fdc++;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ((obs(i) & exp_mask(i)) !== (exp_out(i) & exp_mask(i))) begin
                    errors++;
                    $display("FAIL drop_model dut%0d @%0t got=%h want=%h", i, $time, obs(i), exp_out(i));
                end
            end
        end
        checks++;
        if (fdc != 1) begin errors++; $display("FAIL drop_frame_done got=%0d want=1", fdc); end
        checks++;
        if (sel[0] !== 4'b0000 || blank[0] !== 1'b1) begin
            errors++;
            $display("FAIL drop_idle got=%b/%b want=0000/1", sel[0], blank[0]);
        end
    endtask

    task automatic test_reset_midframe();
        int c;
        enable = 1'b1;
        c = 0;
        while (sel[0] !== 4'b0100 && c < 60) begin @(negedge clk); c++; end
        checks++;
        if (c >= 60) begin errors++; $display("FAIL rst_wait got=none want=digit2"); end
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 11'b0000_0000_010) begin
                errors++;
                $display("FAIL rst_mid dut%0d got=%h want=%h", i, obs(i), 11'b0000_0000_010);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (sel[0] !== 4'b0000 || sel[1] !== 4'b0000) begin
            errors++;
            $display("FAIL rst_load got=%b/%b want=0000/0000", sel[0], sel[1]);
        end
        @(negedge clk);
        checks++;
        if (sel[0] !== 4'b0001 || sel[1] !== 4'b0001) begin
            errors++;
            $display("FAIL rst_first_digit got=%b/%b want=0001/0001", sel[0], sel[1]);
        end
    endtask

    task automatic test_random();
        repeat (2000) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ((obs(i) & exp_mask(i)) !== (exp_out(i) & exp_mask(i))) begin
                    errors++;
                    $display("FAIL random_model dut%0d @%0t got=%h want=%h", i, $time, obs(i), exp_out(i));
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                digits = 16'($urandom);
                if ($urandom_range(0, 1) == 0) digits = digits & 16'h0F0F;
            end
            if ($urandom_range(0, 9) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_leading_zero();
        test_invalid_bcd();
        test_no_tearing();
        test_enable_drop();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
